// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB write master.
package sccb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        STOP,
        DONE
    } sccbState_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_t;

    localparam int SCCB_BITS_PER_WRITE = 27;
    localparam int SCCB_BITS_PER_PHASE = 9;

    // The 9th bit of each phase is the slave's acknowledge slot.
    function automatic logic isAckBit(input logic [4:0] idx);
        return (int'(idx) % SCCB_BITS_PER_PHASE) == (SCCB_BITS_PER_PHASE - 1);
    endfunction

endpackage

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: serialises device/register/data bytes onto an
// open-drain SCL/SDA pair, paced by a quarter-bit clock-enable tick.
module sccb_write_master
    import sccb_pkg::*;
#(
    parameter bit CHECK_ACK = 1'b1
) (
    input  logic       iClk,
    input  logic       iRsn,
    input  logic       iEnClk,
    input  logic       iStart,
    input  logic [7:0] iDevAddr,
    input  logic [7:0] iRegAddr,
    input  logic [7:0] iData,
    input  logic       iSda,
    output logic       oScl,
    output logic       oSdaOe,
    output logic       oBusy,
    output logic       oDone,
    output logic       oAckErr,
    output sccbState_t oState
);

    // Request protocol: iStart is accepted on any cycle while idle (oBusy low);
    // while oBusy is high further requests are dropped, and oDone pulses once
    // when the bus has been released after the STOP condition.

    sccbState_t  state;
    quarter_t    q;
    logic [4:0]  bitIdx;
    logic [23:0] shiftReg;
    logic        ackBit;

    assign oState = state;
    assign ackBit = isAckBit(bitIdx);

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state    <= IDLE;
            q        <= Q0;
            bitIdx   <= '0;
            shiftReg <= '0;
            oScl     <= 1'b1;
            oSdaOe   <= 1'b0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oAckErr  <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    oScl   <= 1'b1;
                    oSdaOe <= 1'b0;
                    oBusy  <= 1'b0;
                    if (iStart) begin
                        shiftReg <= {iDevAddr, iRegAddr, iData};
                        oAckErr  <= 1'b0;
                        q        <= Q0;
                        bitIdx   <= '0;
                        oBusy    <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (iEnClk) begin
                        oScl   <= (q == Q0) || (q == Q1);
                        oSdaOe <= 1'b1;
                        q      <= quarter_t'(q + 2'd1);
                        if (q == Q3) state <= BIT;
                    end
                end
                BIT: begin
                    if (iEnClk) begin
                        q <= quarter_t'(q + 2'd1);
                        case (q)
                            Q0: begin
                                oScl   <= 1'b0;
                                oSdaOe <= ackBit ? 1'b0 : ~shiftReg[23];
                            end
                            Q1: oScl <= 1'b1;
                            Q2: begin
                                oScl <= 1'b1;
                                if (ackBit && iSda && CHECK_ACK) oAckErr <= 1'b1;
                            end
                            default: begin
                                oScl <= 1'b0;
                                // Ack slots carry no payload, so the shifter holds.
                                if (!ackBit) shiftReg <= {shiftReg[22:0], 1'b0};
                                if (bitIdx == 5'(SCCB_BITS_PER_WRITE - 1)) begin
                                    bitIdx <= '0;
                                    state  <= STOP;
                                end else begin
                                    bitIdx <= bitIdx + 5'd1;
                                end
                            end
                        endcase
                    end
                end
                STOP: begin
                    if (iEnClk) begin
                        oScl   <= (q != Q0);
                        oSdaOe <= (q == Q0) || (q == Q1);
                        q      <= quarter_t'(q + 2'd1);
                        if (q == Q3) begin
                            oDone <= 1'b1;
                            oBusy <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench for sccb_write_master: table of write transactions plus
// hand-written sequences for idle, ignored restart and mid-transfer reset.
module tb_sccb_write_master;
    import sccb_pkg::*;

    logic       iClk = 1'b0;
    logic       iRsn = 1'b0;
    logic       iEnClk = 1'b0;
    logic       iStart = 1'b0;
    logic [7:0] iDevAddr = '0;
    logic [7:0] iRegAddr = '0;
    logic [7:0] iData = '0;
    logic       iSda = 1'b0;

    logic       oScl, oSdaOe, oBusy, oDone, oAckErr;
    logic       nScl, nSdaOe, nBusy, nDone, nAckErr;
    sccbState_t oState, nState;

    sccb_write_master #(.CHECK_ACK(1'b1)) dut (
        .iClk(iClk), .iRsn(iRsn), .iEnClk(iEnClk), .iStart(iStart),
        .iDevAddr(iDevAddr), .iRegAddr(iRegAddr), .iData(iData), .iSda(iSda),
        .oScl(oScl), .oSdaOe(oSdaOe), .oBusy(oBusy), .oDone(oDone),
        .oAckErr(oAckErr), .oState(oState)
    );

    sccb_write_master #(.CHECK_ACK(1'b0)) dutNc (
        .iClk(iClk), .iRsn(iRsn), .iEnClk(iEnClk), .iStart(iStart),
        .iDevAddr(iDevAddr), .iRegAddr(iRegAddr), .iData(iData), .iSda(iSda),
        .oScl(nScl), .oSdaOe(nSdaOe), .oBusy(nBusy), .oDone(nDone),
        .oAckErr(nAckErr), .oState(nState)
    );

    always #5 iClk = ~iClk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    // Tick generator and bus monitor state
    logic       contMode = 1'b0;
    int         divCnt = 0;
    logic       prevScl = 1'b1;
    logic       prevOe = 1'b0;
    int         riseCnt = 0;
    int         sdaHiEdges = 0;
    logic       capBits [0:31];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clock: sample outputs after the edge, then set up the next tick.
    task automatic step();
        @(posedge iClk);
        #1;
        if (!prevScl && oScl) begin
            if (riseCnt < 32) capBits[riseCnt] = ~oSdaOe;
            riseCnt++;
        end
        if (prevScl && oScl && (prevOe != oSdaOe)) sdaHiEdges++;
        prevScl = oScl;
        prevOe  = oSdaOe;
        divCnt  = (divCnt + 1) % 4;
        iEnClk  = contMode | (divCnt == 0);
    endtask

    task automatic run_write(input string tag, input logic [7:0] dev, input logic [7:0] regA,
                             input logic [7:0] dat, input logic sda, input logic cont,
                             input logic expErr, input logic expErrNc, input bit interfere);
        int   cnt;
        int   doneCnt;
        bit   done;
        bit   injected;
        logic [7:0] got;
        contMode   = cont;
        iSda       = sda;
        riseCnt    = 0;
        sdaHiEdges = 0;
        exp_q.push_back(dev);
        exp_q.push_back(regA);
        exp_q.push_back(dat);
        iDevAddr = dev;
        iRegAddr = regA;
        iData    = dat;
        iStart   = 1'b1;
        cnt = 0; doneCnt = 0; done = 0; injected = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            step();
            cnt++;
            if (cnt == 1) check({tag, " busy_rise"}, oBusy, 1'b1);
            if (interfere && !injected && riseCnt == 5) begin
                iDevAddr = 8'h99; iRegAddr = 8'h55; iData = 8'hAA;
                iStart   = 1'b1;
                injected = 1;
            end else begin
                iStart = 1'b0;
            end
            if (oDone) begin
                done    = 1;
                doneCnt = 1;
                check({tag, " ack_err"}, oAckErr, expErr);
                check({tag, " ack_err_nocheck"}, nAckErr, expErrNc);
                check({tag, " busy_fall"}, oBusy, 1'b0);
            end
        end
        iStart = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s done_timeout actual=none required=pulse", tag);
            exp_q.delete();
            return;
        end
        // 116 ticks; at DIV=4 allow for tick alignment around the nominal 465.
        if (cont) checkRange({tag, " latency"}, cnt, 116, 118);
        else      checkRange({tag, " latency"}, cnt, 462, 468);
        for (int i = 0; i < 10; i++) begin
            step();
            if (oDone) doneCnt++;
        end
        check({tag, " done_pulses"}, doneCnt, 1);
        check({tag, " scl_rises"}, riseCnt, 28);
        check({tag, " sda_edges_scl_high"}, sdaHiEdges, 2);
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < 8; b++) got[7-b] = capBits[k*9 + b];
            check({tag, " byte"}, got, exp_q.pop_front());
        end
    endtask

    typedef struct {
        logic [7:0] dev;
        logic [7:0] regA;
        logic [7:0] dat;
        logic       sda;
        logic       cont;
        logic       expErr;
        logic       expErrNc;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{8'h42, 8'h12, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h42, 8'h12, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h42, 8'h3A, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hA5, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset and idle
        for (int i = 0; i < 3; i++) step();
        iRsn = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("idle scl", oScl, 1'b1);
        check("idle sda_oe", oSdaOe, 1'b0);
        check("idle busy", oBusy, 1'b0);
        check("idle done", oDone, 1'b0);
        check("idle ack_err", oAckErr, 1'b0);
        check("idle nc scl", nScl, 1'b1);
        check("idle nc busy", nBusy, 1'b0);

        for (int v = 0; v < 4; v++) begin
            run_write($sformatf("vec%0d", v), vecs[v].dev, vecs[v].regA, vecs[v].dat,
                      vecs[v].sda, vecs[v].cont, vecs[v].expErr, vecs[v].expErrNc, 1'b0);
        end

        // Restart request mid-transfer is dropped; the latched bytes go out.
        run_write("ignore_start", 8'h42, 8'h12, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during the second byte, with a NACK already recorded.
        contMode = 1'b0;
        iSda     = 1'b1;
        iDevAddr = 8'h42; iRegAddr = 8'h12; iData = 8'h80;
        iStart   = 1'b1;
        step();
        iStart  = 1'b0;
        riseCnt = 0;
        for (int i = 0; i < 2000 && riseCnt < 12; i++) step();
        check("pre_reset ack_err", oAckErr, 1'b1);
        iRsn = 1'b0;
        #1;
        check("reset scl", oScl, 1'b1);
        check("reset sda_oe", oSdaOe, 1'b0);
        check("reset busy", oBusy, 1'b0);
        check("reset done", oDone, 1'b0);
        check("reset ack_err", oAckErr, 1'b0);
        step();
        step();
        iRsn = 1'b1;
        step();
        run_write("post_reset", 8'h42, 8'h3A, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_write_master.md
# sccb_write_master

SCCB (I2C-compatible) 3-phase write master for camera register configuration. It is paced by the `wEnClk`-style one-cycle tick from the parent's clock-enable generator: four ticks make one SCL bit period. It serialises device address, register address and data onto an open-drain SCL/SDA pair, then reports completion. It sits between the camera-config sequencer (upstream) and the sensor pads (downstream).

## Interface
- `CHECK_ACK`, default 1: 1 means a sampled high on the 9th bit sets `oAckErr`; 0 means `oAckErr` is held at 0.

- `iClk`, in, 1: system clock.
- `iRsn`, in, 1: asynchronous, active-low reset.
- `iEnClk`, in, 1: quarter-bit tick, one `iClk` wide.
- `iStart`, in, 1: request a write. Sampled only in IDLE.
- `iDevAddr`, in, 8: device write address (e.g. 0x42). Latched on accept.
- `iRegAddr`, in, 8: register address. Latched on accept.
- `iData`, in, 8: register data. Latched on accept.
- `iSda`, in, 1: SDA pad input.
- `oScl`, out, 1: SCL level (1 = released/high).
- `oSdaOe`, out, 1: 1 pulls SDA low; 0 releases it (pad output tied 0).
- `oBusy`, out, 1: high from the cycle after accept until `oDone`.
- `oDone`, out, 1: one-cycle completion pulse.
- `oAckErr`, out, 1: NACK seen in the last transaction. Valid from `oDone`.

## Operation
- States: IDLE → START → BIT → STOP → DONE → IDLE.
- Quarter counter `q` (2 bits) advances only on `iEnClk`. The state moves on the tick that ends q3.
- IDLE:
  - `oScl`=1, `oSdaOe`=0, `oBusy`=0.
  - `iStart`=1 on any cycle (no tick needed) latches {`iDevAddr`,`iRegAddr`,`iData`} into a 24-bit shift register, clears `oAckErr` and `q`, sets bit index 0, and enters START.
- START:
  - q0, q1: SCL=1, SDA pulled low.
  - q2, q3: SCL=0, SDA low.
- BIT: 27 bits = 3 × (8 data bits, MSB first, + 1 don't-care bit).
  - q0: SCL=0; `oSdaOe` = ~data bit, or 0 on bit 9.
  - q1, q2: SCL=1.
  - q2 tick of bit 9: sample `iSda`; if it is 1 and `CHECK_ACK`=1, set `oAckErr`.
  - q3: SCL=0.
  - After bit 9 of byte 3, go to STOP.
- STOP:
  - q0: SCL=0, SDA low.
  - q1: SCL=1, SDA low.
  - q2, q3: SCL=1, SDA released.
- DONE: `oDone`=1 for one cycle, `oBusy`→0, then IDLE. DONE takes no tick.
- `iStart` outside IDLE is ignored. Latched inputs do not change mid-transaction.
- Reset asserted mid-transfer immediately forces IDLE outputs: bus released, `oBusy`=`oDone`=`oAckErr`=0. No STOP is generated.

## Timing
- All outputs are registered. A pad level changes on the `iClk` edge after the tick that enters the quarter.
- Transaction length is 116 ticks (4 START + 108 BIT + 4 STOP). With the enable generator at DIV=4: 464 cycles from the first tick to DONE, plus tick-alignment slack of ≤3 cycles.
- `oBusy` rises 1 cycle after `iStart` is accepted. `oDone` appears 1 cycle after the final STOP q3 tick.
- SDA changes only while SCL=0, except in START and STOP.
- `iEnClk` held high continuously is legal: one quarter per cycle.
- `iEnClk` coinciding with `iStart` in IDLE: accept only. The first quarter of START begins on the next tick.
- Reset values: `oScl`=1, `oSdaOe`=0, `oBusy`=0, `oDone`=0, `oAckErr`=0.

## Structure
- Package `sccb_pkg`:
  - state enum: IDLE, START, BIT, STOP, DONE;
  - quarter encodings Q0..Q3;
  - `SCCB_BITS_PER_WRITE`=27;
  - `SCCB_BITS_PER_PHASE`=9.
- Single module; no sub-module. The tick comes from the existing clock-enable generator, instantiated in the parent.
- Bit index counter: 5 bits (0..26). The byte boundary is bit index mod 9 == 8.

## Test plan
- Reset, then idle for 20 cycles → `oScl`=1, `oSdaOe`=0, `oBusy`=0.
- Write 0x42/0x12/0x80, `iSda` tied 0, DIV=4 → SDA bit stream 01000010_x 00010010_x 10000000_x; `oDone` exactly 465±3 cycles after `iStart`; `oAckErr`=0.
- Same write with `iSda`=1 (bus pulled up, no slave) → `oAckErr`=1 at `oDone`. Repeat with `CHECK_ACK`=0 → `oAckErr`=0.
- Pulse `iStart` with new data at bit 5 of the transfer → ignored; the original bytes complete; exactly one `oDone`.
- Assert `iRsn` low during the second byte → in the same cycle `oScl`=1 and `oSdaOe`=0. After release, a new write 0x42/0x3A/0x04 completes correctly.
- Hold `iEnClk`=1 continuously → transaction takes 116+2 cycles; SDA never toggles while SCL=1 outside START/STOP (assertion).
